// File: rtl/receive_engine.sv
// UART receive engine: synchronises RX, frames 7/8 data bits, optional parity and one stop bit.
// Latency: SYNC_STAGES + baud/2 + (N+1)*baud + 2 clocks from the RX start edge to RXRDY.
// No backpressure: a frame completing while RXRDY is still set overwrites rx_data and raises OVF.
module receive_engine #(
  parameter int SYNC_STAGES = 2,
  parameter int BAUD_W      = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RX,
  input  logic              read0,
  input  logic [BAUD_W-1:0] baud,
  input  logic              EIGHT,
  input  logic              PEN,
  input  logic              OHEL,
  output logic [7:0]        rx_data,
  output logic              RXRDY,
  output logic              PERR,
  output logic              FERR,
  output logic              OVF
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_s_d;
  state_t                 state;
  logic [BAUD_W-1:0]      cnt;
  logic [BAUD_W-1:0]      baud_l;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg;
  logic                   eight_l;
  logic                   pen_l;
  logic                   ohel_l;
  logic                   perr_n;
  logic                   ferr_n;
  logic                   commit;
  logic                   tick;
  logic [7:0]             data_w;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // The counter is loaded with a bit time and "expires" on the clock where it steps down to
  // zero, so a load of baud spans exactly baud clocks and the half-bit load lands mid-bit.
  assign tick = (cnt == BAUD_W'(1));

  // Bits enter at bit 7 and shift right, so a 7-bit frame ends up in shreg[7:1].
  assign data_w = eight_l ? shreg : {1'b0, shreg[7:1]};

  // Metastability synchroniser plus one extra flop for start-edge detection; idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      rx_s_d <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
      rx_s_d <= rx_s;
    end
  end

  // Frame FSM. A start needs a 1->0 edge on rx_s, so a line held low after a framing error
  // (break) cannot re-trigger until it has returned high. Commit is a one-cycle strobe issued
  // while the FSM is already back in IDLE, so a start edge in that cycle is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      baud_l  <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      eight_l <= 1'b0;
      pen_l   <= 1'b0;
      ohel_l  <= 1'b0;
      perr_n  <= 1'b0;
      ferr_n  <= 1'b0;
      commit  <= 1'b0;
    end else begin
      commit <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_s_d && !rx_s) begin
            baud_l  <= baud;
            eight_l <= EIGHT;
            pen_l   <= PEN;
            ohel_l  <= OHEL;
            cnt     <= baud >> 1;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            if (rx_s) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt    <= baud_l;
              bitcnt <= '0;
              perr_n <= 1'b0;
              state  <= DATA;
            end
          end else begin
            cnt <= cnt - BAUD_W'(1);
          end
        end
        DATA: begin
          if (tick) begin
            shreg  <= {rx_s, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            cnt    <= baud_l;
            if (bitcnt == {2'b11, eight_l}) state <= pen_l ? PARITY : STOP;
          end else begin
            cnt <= cnt - BAUD_W'(1);
          end
        end
        PARITY: begin
          if (tick) begin
            perr_n <= rx_s ^ (^data_w) ^ ohel_l;
            cnt    <= baud_l;
            state  <= STOP;
          end else begin
            cnt <= cnt - BAUD_W'(1);
          end
        end
        STOP: begin
          if (tick) begin
            ferr_n <= ~rx_s;
            commit <= 1'b1;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - BAUD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Host-visible byte and flags. A commit coinciding with read0 wins, and the flags then
  // reflect only the frame just committed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data <= '0;
      RXRDY   <= 1'b0;
      PERR    <= 1'b0;
      FERR    <= 1'b0;
      OVF     <= 1'b0;
    end else if (commit) begin
      rx_data <= data_w;
      RXRDY   <= 1'b1;
      if (read0) begin
        PERR <= perr_n & pen_l;
        FERR <= ferr_n;
        OVF  <= RXRDY;
      end else begin
        PERR <= PERR | (perr_n & pen_l);
        FERR <= FERR | ferr_n;
        OVF  <= OVF | RXRDY;
      end
    end else if (read0) begin
      RXRDY <= 1'b0;
      PERR  <= 1'b0;
      FERR  <= 1'b0;
      OVF   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_receive_engine.sv
// Directed bench for receive_engine at 868 clocks per bit.
// Frames are driven LSB-first on negative edges; outputs are sampled on negative edges.
// Covers reset, 8N1, 7-bit parity, framing error, glitch rejection, overrun and mid-frame reset.
module tb_receive_engine;

  localparam int BAUD    = 868;
  localparam int LAT_8N1 = 2 + BAUD / 2 + 9 * BAUD + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RX = 1'b1;
  logic        read0 = 1'b0;
  logic [18:0] baud = 19'(BAUD);
  logic        EIGHT = 1'b1;
  logic        PEN = 1'b0;
  logic        OHEL = 1'b0;
  logic [7:0]  rx_data;
  logic        RXRDY;
  logic        PERR;
  logic        FERR;
  logic        OVF;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  logic rxrdy_q = 1'b0;

  receive_engine #(.SYNC_STAGES(2), .BAUD_W(19)) dut (
    .clk(clk), .reset(reset), .RX(RX), .read0(read0), .baud(baud),
    .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL),
    .rx_data(rx_data), .RXRDY(RXRDY), .PERR(PERR), .FERR(FERR), .OVF(OVF)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (RXRDY && !rxrdy_q) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    rxrdy_q <= RXRDY;
  end

  // Caller must be at a negative edge; returns at a negative edge with the line idle.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop_v);
    RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < (EIGHT ? 8 : 7); i++) begin
      RX = d[i];
      repeat (BAUD) @(negedge clk);
    end
    if (PEN) begin
      RX = p;
      repeat (BAUD) @(negedge clk);
    end
    RX = stop_v;
    repeat (BAUD) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic pulse_read0();
    @(negedge clk);
    read0 = 1'b1;
    @(negedge clk);
    read0 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (RXRDY !== 1'b0) begin errors++; $display("FAIL reset_rxrdy: got %b expected 0", RXRDY); end
    checks++; if (PERR !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", PERR); end
    checks++; if (FERR !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", FERR); end
    checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", OVF); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_8n1();
    int base;
    int c0;
    EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
    base = rise_cnt;
    c0 = cyc;
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (rise_cnt - base !== 1) begin errors++; $display("FAIL t1_rises: got %0d expected 1", rise_cnt - base); end
    checks++; if ((rise_cyc - c0 < LAT_8N1 - 2) || (rise_cyc - c0 > LAT_8N1 + 2)) begin
      errors++; $display("FAIL t1_latency: got %0d expected %0d +/-2", rise_cyc - c0, LAT_8N1); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL t1_data: got %h expected 55", rx_data); end
    checks++; if ({PERR, FERR, OVF} !== 3'b000) begin errors++; $display("FAIL t1_flags: got %b expected 000", {PERR, FERR, OVF}); end
    pulse_read0();
  endtask

  task automatic test_parity7();
    EIGHT = 1'b0; PEN = 1'b1; OHEL = 1'b0;
    send_frame(8'h41, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (rx_data !== 8'h41) begin errors++; $display("FAIL t2_data_good: got %h expected 41", rx_data); end
    checks++; if (PERR !== 1'b0) begin errors++; $display("FAIL t2_perr_good: got %b expected 0", PERR); end
    pulse_read0();
    send_frame(8'h41, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (rx_data !== 8'h41) begin errors++; $display("FAIL t2_data_bad: got %h expected 41", rx_data); end
    checks++; if (PERR !== 1'b1) begin errors++; $display("FAIL t2_perr_bad: got %b expected 1", PERR); end
    checks++; if (RXRDY !== 1'b1) begin errors++; $display("FAIL t2_rxrdy: got %b expected 1", RXRDY); end
    pulse_read0();
  endtask

  task automatic test_framing();
    EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    checks++; if (FERR !== 1'b1) begin errors++; $display("FAIL t3_ferr: got %b expected 1", FERR); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL t3_data: got %h expected a5", rx_data); end
    pulse_read0();
    checks++; if (FERR !== 1'b0) begin errors++; $display("FAIL t3_ferr_clr: got %b expected 0", FERR); end
    checks++; if (RXRDY !== 1'b0) begin errors++; $display("FAIL t3_rxrdy_clr: got %b expected 0", RXRDY); end
  endtask

  task automatic test_glitch();
    int base;
    base = rise_cnt;
    RX = 1'b0;
    repeat (300) @(negedge clk);
    RX = 1'b1;
    repeat (1000) @(negedge clk);
    checks++; if (rise_cnt - base !== 0) begin errors++; $display("FAIL t4_no_rise: got %0d expected 0", rise_cnt - base); end
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL t4_data: got %h expected 3c", rx_data); end
    checks++; if ({RXRDY, PERR, FERR, OVF} !== 4'b1000) begin
      errors++; $display("FAIL t4_flags: got %b expected 1000", {RXRDY, PERR, FERR, OVF}); end
    pulse_read0();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL t5_data: got %h expected 22", rx_data); end
    checks++; if (OVF !== 1'b1) begin errors++; $display("FAIL t5_ovf: got %b expected 1", OVF); end
    pulse_read0();
    checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL t5_ovf_clr: got %b expected 0", OVF); end
    // Second pass: read0 lands exactly on the second frame's commit clock.
    fork
      begin
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
      end
      begin
        repeat (10 * BAUD + LAT_8N1 - 1) @(negedge clk);
        read0 = 1'b1;
        @(negedge clk);
        read0 = 1'b0;
        checks++; if (RXRDY !== 1'b1) begin errors++; $display("FAIL t5_coll_rxrdy: got %b expected 1", RXRDY); end
        checks++; if (OVF !== 1'b1) begin errors++; $display("FAIL t5_coll_ovf: got %b expected 1", OVF); end
        checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL t5_coll_data: got %h expected 22", rx_data); end
      end
    join
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int base;
    fork
      send_frame(8'hFF, 1'b0, 1'b1);
      begin
        repeat (3000) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({RXRDY, PERR, FERR, OVF} !== 4'b0000) begin
          errors++; $display("FAIL t6_flags_rst: got %b expected 0000", {RXRDY, PERR, FERR, OVF}); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL t6_data_rst: got %h expected 00", rx_data); end
        repeat (4) @(negedge clk);
        reset = 1'b1;
      end
    join
    base = rise_cnt;
    repeat (2000) @(negedge clk);
    checks++; if (rise_cnt - base !== 0 || RXRDY !== 1'b0) begin
      errors++; $display("FAIL t6_no_commit: got rises %0d rxrdy %b expected 0 0", rise_cnt - base, RXRDY); end
    send_frame(8'h5A, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL t6_data: got %h expected 5a", rx_data); end
    checks++; if ({RXRDY, PERR, FERR, OVF} !== 4'b1000) begin
      errors++; $display("FAIL t6_flags: got %b expected 1000", {RXRDY, PERR, FERR, OVF}); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_8n1();
    test_parity7();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
